// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: intake FSM states and the
// default FIFO depth.
package uart_pkg;

    localparam int UART_RX_FIFO_DEPTH_DEFAULT = 16;

    // Intake handshake with the UART's single-byte valid/rd interface.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rx_fifo_state_t;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// fifo_ram: DEPTH x 8 storage, one synchronous write port and one
// asynchronous read port so it maps onto distributed RAM. Entries carry no
// reset; the reader masks stale contents with its own empty flag.
module fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write port: one byte per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives the show-ahead head byte with no latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains bytes from the UART receiver into a show-ahead FIFO
// and presents head byte, fill level and flags to the CPU bus.
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN -- when defined, a byte
// arriving while full is acknowledged and discarded and a sticky overrun flag
// is raised; when undefined the byte is left waiting in the UART.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_ni,
    input  logic          uart_valid_i,
    input  logic [7:0]    uart_data_i,
    output logic          uart_rd_o,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [7:0]    data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o,
    output logic          overrun_o
);

    localparam int AW = $clog2(DEPTH);

    rx_fifo_state_t state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           empty_reg, full_reg, uart_rd_reg;
    logic           push, pop;
    logic [7:0]     ram_rdata;

    // Intake FSM, push/pop qualification and pointer/count arithmetic.
    always_comb begin
        state_next  = state_reg;
        push        = 1'b0;
        pop         = pop_i && !empty_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        case (state_reg)
            IDLE: begin
                // Push uses the full flag as registered this cycle, so a
                // simultaneous pop never lets a push into a full FIFO.
                if (uart_valid_i && !full_reg) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
`ifdef UART_RX_FIFO_OVERRUN_EN
                else if (uart_valid_i) begin
                    // Acknowledge and drop the byte; overrun is flagged below.
                    state_next = ACK;
                end
`endif
            end
            ACK:     state_next = WAIT;
            // Hold off until the UART has seen rd and lowered valid.
            WAIT:    if (!uart_valid_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (flush_i) begin
            // Flush wins over any push/pop; parking in WAIT stops the byte
            // still held by the UART from being captured a second time.
            push        = 1'b0;
            pop         = 1'b0;
            state_next  = WAIT;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // State, pointers, count and registered flag outputs.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            uart_rd_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            empty_reg   <= (count_next == '0);
            full_reg    <= (count_next == CW'(DEPTH));
            uart_rd_reg <= (state_next == ACK);
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_reg;

    // Sticky byte-lost flag, cleared only by flush or reset.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            overrun_reg <= 1'b0;
        end else if (flush_i) begin
            overrun_reg <= 1'b0;
        end else if (state_reg == IDLE && uart_valid_i && full_reg) begin
            overrun_reg <= 1'b1;
        end
    end

    assign overrun_o = overrun_reg;
`else
    assign overrun_o = 1'b0;
`endif

    fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (uart_data_i),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    assign uart_rd_o = uart_rd_reg;
    assign empty_o   = empty_reg;
    assign full_o    = full_reg;
    assign count_o   = count_reg;
    assign data_o    = empty_reg ? 8'h00 : ram_rdata;

endmodule
